// File: rtl/byte_unstriping.sv
// Reassembles bytes from a 4-lane nibble stream (low nibble first) and queues them
// in a small first-word-fall-through FIFO with overflow detection and a byte counter.
module byte_unstriping #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       byteUnstripingCLK,
  input  logic       byteUnstripingRST,
  input  logic       stripedLane0,
  input  logic       stripedLane1,
  input  logic       stripedLane2,
  input  logic       stripedLane3,
  input  logic       stripedVLD,
  input  logic       stripedSYNC,
  input  logic       byteUnstripingRDY,
  output logic [7:0] byteUnstripingOUT,
  output logic       byteUnstripingVLD,
  output logic       fifoFull,
  output logic       overflowERR,
  output logic [7:0] byteCount
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthCnt = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {PhLo, PhHi} phase_e;

  phase_e          phase_q, phase_d;
  logic [3:0]      nibble_q, nibble_d;
  logic [3:0]      lanes;
  logic            complete;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            ovf_q;
  logic [7:0]      byte_cnt_q;
  logic            full, not_empty, push, pop, ovf_set;

  assign lanes = {stripedLane3, stripedLane2, stripedLane1, stripedLane0};

  // A SYNC beat always restarts the byte, discarding any pending low nibble.
  always_comb begin
    phase_d  = phase_q;
    nibble_d = nibble_q;
    complete = 1'b0;
    if (stripedVLD) begin
      if (phase_q == PhLo || stripedSYNC) begin
        nibble_d = lanes;
        phase_d  = PhHi;
      end else begin
        complete = 1'b1;
        phase_d  = PhLo;
      end
    end
  end

  always_ff @(posedge byteUnstripingCLK) begin
    if (byteUnstripingRST) begin
      phase_q  <= PhLo;
      nibble_q <= 4'h0;
    end else begin
      phase_q  <= phase_d;
      nibble_q <= nibble_d;
    end
  end

  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == DepthCnt);
    pop       = not_empty && byteUnstripingRDY;
    // A same-cycle pop frees the slot the completing byte needs.
    push      = complete && (!full || pop);
    ovf_set   = complete && full && !pop;
  end

  always_ff @(posedge byteUnstripingCLK) begin
    if (!byteUnstripingRST && push) begin
      mem_q[wr_ptr_q] <= {lanes, nibble_q};
    end
  end

  always_ff @(posedge byteUnstripingCLK) begin
    if (byteUnstripingRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      byte_cnt_q <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + AW'(1);
        byte_cnt_q <= byte_cnt_q + 8'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (AW + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (AW + 1)'(1);
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign byteUnstripingVLD = not_empty;
  assign byteUnstripingOUT = not_empty ? mem_q[rd_ptr_q] : 8'h00;
  assign fifoFull          = full;
  assign overflowERR       = ovf_q;
  assign byteCount         = byte_cnt_q;

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: inputs driven and outputs checked on the falling edge.
module tb_byte_unstriping;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lanes;
  logic       vld, sync, rdy;
  logic [7:0] out_byte;
  logic       out_vld, full, ovf;
  logic [7:0] cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  byte_unstriping #(.FIFO_DEPTH(4)) dut (
    .byteUnstripingCLK(clk),
    .byteUnstripingRST(rst),
    .stripedLane0(lanes[0]),
    .stripedLane1(lanes[1]),
    .stripedLane2(lanes[2]),
    .stripedLane3(lanes[3]),
    .stripedVLD(vld),
    .stripedSYNC(sync),
    .byteUnstripingRDY(rdy),
    .byteUnstripingOUT(out_byte),
    .byteUnstripingVLD(out_vld),
    .fifoFull(full),
    .overflowERR(ovf),
    .byteCount(cnt)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] l, input logic s);
    lanes = l;
    vld   = 1'b1;
    sync  = s;
    tick();
    vld   = 1'b0;
    sync  = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    beat(b[3:0], 1'b0);
    beat(b[7:4], 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [$];
    rst = 1'b1; lanes = 4'h0; vld = 1'b0; sync = 1'b0; rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_out", out_byte, 8'h00);
    check("reset_vld", {7'd0, out_vld}, 8'd0);
    check("reset_full", {7'd0, full}, 8'd0);
    check("reset_ovf", {7'd0, ovf}, 8'd0);
    check("reset_cnt", cnt, 8'd0);

    // Single byte A5 with downstream ready
    rdy = 1'b1;
    push_byte(8'hA5);
    check("a5_out", out_byte, 8'hA5);
    check("a5_vld", {7'd0, out_vld}, 8'd1);
    check("a5_cnt", cnt, 8'd1);
    tick();
    check("a5_popped_vld", {7'd0, out_vld}, 8'd0);
    tick();
    check("empty_pop_cnt", cnt, 8'd1);

    // Resync discards the 1111 nibble
    rdy = 1'b0;
    beat(4'b1111, 1'b0);
    beat(4'b0011, 1'b1);
    check("sync_no_byte", {7'd0, out_vld}, 8'd0);
    beat(4'b1100, 1'b0);
    check("sync_out", out_byte, 8'hC3);
    check("sync_vld", {7'd0, out_vld}, 8'd1);
    check("sync_cnt", cnt, 8'd2);
    rdy = 1'b1;
    tick();
    check("sync_drained", {7'd0, out_vld}, 8'd0);

    // Gap between beats; SYNC without VLD is ignored
    rdy = 1'b0;
    beat(4'b0111, 1'b0);
    sync = 1'b1;
    tick();
    tick();
    sync = 1'b0;
    tick();
    beat(4'b1110, 1'b0);
    check("gap_out", out_byte, 8'hE7);
    check("gap_cnt", cnt, 8'd3);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;

    // Overflow: five bytes into a depth-4 buffer
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i));
      if (i == 4) begin
        check("ovf_full4", {7'd0, full}, 8'd1);
        check("ovf_not_yet", {7'd0, ovf}, 8'd0);
      end
    end
    check("ovf_full", {7'd0, full}, 8'd1);
    check("ovf_flag", {7'd0, ovf}, 8'd1);
    check("ovf_cnt", cnt, 8'd4);
    rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_drain_out", out_byte, 8'(i));
      check("ovf_drain_vld", {7'd0, out_vld}, 8'd1);
      tick();
    end
    check("ovf_drain_empty", {7'd0, out_vld}, 8'd0);
    check("ovf_drain_notfull", {7'd0, full}, 8'd0);
    check("ovf_sticky", {7'd0, ovf}, 8'd1);
    rdy = 1'b0;

    // Full buffer with a pop on the completing cycle
    do_reset();
    push_byte(8'h10);
    push_byte(8'h20);
    push_byte(8'h30);
    push_byte(8'h40);
    check("fp_full", {7'd0, full}, 8'd1);
    beat(4'h5, 1'b0);
    rdy = 1'b1;
    beat(4'h5, 1'b0);
    rdy = 1'b0;
    check("fp_no_ovf", {7'd0, ovf}, 8'd0);
    check("fp_still_full", {7'd0, full}, 8'd1);
    check("fp_head", out_byte, 8'h20);
    check("fp_cnt", cnt, 8'd5);
    exp_q = '{8'h20, 8'h30, 8'h40, 8'h55};
    rdy = 1'b1;
    foreach (exp_q[i]) begin
      check("fp_drain_out", out_byte, exp_q[i]);
      tick();
    end
    check("fp_drain_empty", {7'd0, out_vld}, 8'd0);
    rdy = 1'b0;

    // Reset mid-byte, with a beat presented during reset
    do_reset();
    push_byte(8'hA5);
    beat(4'b0110, 1'b0);
    rst = 1'b1;
    beat(4'b1111, 1'b0);
    rst = 1'b0;
    check("rst_out", out_byte, 8'h00);
    check("rst_vld", {7'd0, out_vld}, 8'd0);
    check("rst_full", {7'd0, full}, 8'd0);
    check("rst_ovf", {7'd0, ovf}, 8'd0);
    check("rst_cnt", cnt, 8'd0);
    beat(4'b1001, 1'b0);
    beat(4'b0000, 1'b0);
    check("rst_after_out", out_byte, 8'h09);
    check("rst_after_cnt", cnt, 8'd1);

    // Counter and pointer wrap
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 253; i++) begin
      push_byte(8'(i));
    end
    tick();
    check("wrap_drained", {7'd0, out_vld}, 8'd0);
    rdy = 1'b0;
    push_byte(8'hFD);
    push_byte(8'hFE);
    push_byte(8'hFF);
    check("wrap_cnt0", cnt, 8'd0);
    check("wrap_notfull", {7'd0, full}, 8'd0);
    push_byte(8'h00);
    check("wrap_cnt1", cnt, 8'd1);
    check("wrap_full", {7'd0, full}, 8'd1);
    exp_q = '{8'hFD, 8'hFE, 8'hFF, 8'h00};
    rdy = 1'b1;
    foreach (exp_q[i]) begin
      check("wrap_order", out_byte, exp_q[i]);
      tick();
    end
    check("wrap_empty", {7'd0, out_vld}, 8'd0);
    check("wrap_no_ovf", {7'd0, ovf}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
